// File: rtl/ioctl_rom_writer.sv
// rtl/ioctl_rom_writer.sv - buffers toggle-strobed ioctl words and writes them to the SDRAM ROM port via req/ack toggles.
// Optional header skip is enabled by defining ROM_COPIER_HDR_SKIP_EN.
module ioctl_rom_writer #(
    parameter int ADDR_W          = 24,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic [23:0]       ioctl_filesize,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_size,
    output logic              rom_loaded,
    output logic              overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOADING, S_DRAIN} state_e;

    state_e                     state_q, state_d;
    logic                       wr_q, dl_q;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d, rom_size_q, rom_size_d;
    logic [15:0]                mem_din_q, mem_din_d;
    logic                       mem_req_q, mem_req_d;
    logic                       overflow_q, overflow_d, loaded_q, loaded_d;
    logic [ADDR_W+15:0]         fifo_mem [DEPTH];

    logic              dl_rise, dl_fall, push_evt, skip, push_ok, drop, pop, empty, full, req_idle;
    logic [24:0]       addr_adj;
    logic [ADDR_W-1:0] size_base, size_cand;
    logic              unused_bits;
`ifdef ROM_COPIER_HDR_SKIP_EN
    logic              hdr_q, hdr_d;
`endif

    assign unused_bits = ^{ioctl_filesize, addr_adj};

    always_comb begin
        dl_rise  = ioctl_download & ~dl_q;
        dl_fall  = ~ioctl_download & dl_q;
        push_evt = ioctl_wr ^ wr_q;
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        req_idle = (mem_req_q == mem_ack);
        pop      = ~empty & req_idle;
`ifdef ROM_COPIER_HDR_SKIP_EN
        // The header flag is latched from the size seen at download start; the start edge itself already uses it.
        hdr_d    = dl_rise ? (ioctl_filesize[9:0] == 10'h200) : hdr_q;
        skip     = hdr_d & (ioctl_addr < 25'h200);
        addr_adj = hdr_d ? (ioctl_addr - 25'h200) : ioctl_addr;
`else
        skip     = 1'b0;
        addr_adj = ioctl_addr;
`endif
        // A pop in the same edge frees a slot, so a full FIFO still accepts the word.
        push_ok  = push_evt & ~skip & (~full | pop);
        drop     = push_evt & ~skip & full & ~pop;

        size_base  = dl_rise ? '0 : rom_size_q;
        size_cand  = addr_adj[ADDR_W-1:0] + ADDR_W'(2);
        rom_size_d = (push_ok && (size_cand > size_base)) ? size_cand : size_base;
        overflow_d = (overflow_q & ~dl_rise) | drop;

        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_req_d  = mem_req_q;
        rd_ptr_d   = rd_ptr_q;
        if (pop) begin
            mem_addr_d = fifo_mem[rd_ptr_q][ADDR_W+15:16];
            mem_din_d  = fifo_mem[rd_ptr_q][15:0];
            mem_req_d  = ~mem_req_q;
            rd_ptr_d   = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        end
        wr_ptr_d = push_ok ? (wr_ptr_q + FIFO_DEPTH_LOG2'(1)) : wr_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);

        state_d  = state_q;
        loaded_d = 1'b0;
        case (state_q)
            S_IDLE:    if (dl_rise) state_d = S_LOADING;
            S_LOADING: if (dl_fall) state_d = S_DRAIN;
            S_DRAIN: begin
                if (dl_rise) begin
                    state_d = S_LOADING;
                end else if (empty && req_idle) begin
                    state_d  = S_IDLE;
                    loaded_d = 1'b1;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            dl_q       <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_req_q  <= 1'b0;
            rom_size_q <= '0;
            overflow_q <= 1'b0;
            loaded_q   <= 1'b0;
`ifdef ROM_COPIER_HDR_SKIP_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_q       <= ioctl_wr;
            dl_q       <= ioctl_download;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_req_q  <= mem_req_d;
            rom_size_q <= rom_size_d;
            overflow_q <= overflow_d;
            loaded_q   <= loaded_d;
`ifdef ROM_COPIER_HDR_SKIP_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {addr_adj[ADDR_W-1:0], ioctl_dout};
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_req    = mem_req_q;
    assign rom_size   = rom_size_q;
    assign rom_loaded = loaded_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != S_IDLE) | ~empty | ~req_idle;
endmodule
